// File: rtl/uart_baud_generator.sv
// Fractional (phase-accumulator) UART baud generator: oversample tick, mid-bit and
// end-of-bit strobes, eight preset rates plus a run-time custom rate, and phase resync.
module uart_baud_generator #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int ACC_W       = 32,
  parameter int TI_W        = $clog2(OVERSAMPLE)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [2:0]      baud_select,
  input  logic            use_custom,
  input  logic [19:0]     custom_baud,
  input  logic            resync,
  output logic            sample_enable,
  output logic            mid_bit_enable,
  output logic            bit_enable,
  output logic [TI_W-1:0] tick_index,
  output logic            config_error
);

  localparam logic [ACC_W-1:0] CLK_F   = ACC_W'(CLK_FREQ_HZ);
  localparam logic [ACC_W-1:0] INC_MAX = ACC_W'(CLK_FREQ_HZ / 2);
  localparam logic [ACC_W-1:0] OS_W    = ACC_W'(OVERSAMPLE);
  localparam logic [ACC_W-1:0] ZERO_W  = {ACC_W{1'b0}};
  localparam logic [TI_W-1:0]  TI_LAST = TI_W'(OVERSAMPLE - 1);
  localparam logic [TI_W-1:0]  TI_MID  = TI_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TI_W-1:0]  TI_ZERO = {TI_W{1'b0}};

  function automatic logic [ACC_W-1:0] preset_rate(input logic [2:0] sel);
    logic [ACC_W-1:0] r;
    case (sel)
      3'b000:  r = ACC_W'(32'd300);
      3'b001:  r = ACC_W'(32'd1200);
      3'b010:  r = ACC_W'(32'd4800);
      3'b011:  r = ACC_W'(32'd9600);
      3'b100:  r = ACC_W'(32'd19200);
      3'b101:  r = ACC_W'(32'd38400);
      3'b110:  r = ACC_W'(32'd57600);
      3'b111:  r = ACC_W'(32'd115200);
      default: r = ACC_W'(32'd115200);
    endcase
    return r;
  endfunction

  logic [ACC_W-1:0] rate_s, inc_new_s, sum_s;
  logic             inc_valid_s, restart_s, tick_due_s;
  logic [ACC_W-1:0] inc_n_s, acc_n_s;
  logic [TI_W-1:0]  ti_n_s;
  logic             err_n_s, sample_n_s, mid_n_s, bit_n_s;

  logic [ACC_W-1:0] inc_r, acc_r;
  logic [TI_W-1:0]  ti_r;
  logic             first_r, err_r, sample_r, mid_r, bit_r;

  // Next-state: restart beats the enable gate, which beats normal accumulation.
  always_comb begin
    rate_s      = use_custom ? ACC_W'(custom_baud) : preset_rate(baud_select);
    inc_new_s   = rate_s * OS_W;
    inc_valid_s = (inc_new_s != ZERO_W) && (inc_new_s <= INC_MAX);
    restart_s   = first_r || resync || (inc_new_s != inc_r);
    sum_s       = acc_r + inc_r;
    tick_due_s  = (sum_s >= CLK_F);

    inc_n_s    = inc_r;
    acc_n_s    = acc_r;
    ti_n_s     = ti_r;
    err_n_s    = err_r;
    sample_n_s = 1'b0;
    mid_n_s    = 1'b0;
    bit_n_s    = 1'b0;

    if (restart_s) begin
      inc_n_s = inc_new_s;
      acc_n_s = ZERO_W;
      ti_n_s  = TI_ZERO;
      err_n_s = !inc_valid_s;
    end else if (enable && !err_r) begin
      if (tick_due_s) begin
        acc_n_s    = sum_s - CLK_F;
        sample_n_s = 1'b1;
        mid_n_s    = (ti_r == TI_MID);
        if (ti_r == TI_LAST) begin
          ti_n_s  = TI_ZERO;
          bit_n_s = 1'b1;
        end else begin
          ti_n_s = ti_r + TI_W'(1'b1);
        end
      end else begin
        acc_n_s = sum_s;
      end
    end else begin
      acc_n_s = acc_r;
    end
  end

  // State and output registers; first_r forces a restart on the first edge after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_r  <= 1'b1;
      inc_r    <= ZERO_W;
      acc_r    <= ZERO_W;
      ti_r     <= TI_ZERO;
      err_r    <= 1'b0;
      sample_r <= 1'b0;
      mid_r    <= 1'b0;
      bit_r    <= 1'b0;
    end else begin
      first_r  <= 1'b0;
      inc_r    <= inc_n_s;
      acc_r    <= acc_n_s;
      ti_r     <= ti_n_s;
      err_r    <= err_n_s;
      sample_r <= sample_n_s;
      mid_r    <= mid_n_s;
      bit_r    <= bit_n_s;
    end
  end

  assign sample_enable  = sample_r;
  assign mid_bit_enable = mid_r;
  assign bit_enable     = bit_r;
  assign tick_index     = ti_r;
  assign config_error   = err_r;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Directed self-checking bench for uart_baud_generator: expected tick edges come from
// the closed form "ticks after edge k = floor(k*inc/CLK)" and hand-computed constants.
module tb_uart_baud_generator;

  localparam longint CLK_HZ = 64'd50_000_000;
  localparam int     OS     = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] baud_select;
  logic       use_custom;
  logic [19:0] custom_baud;
  logic       resync;
  logic       sample_enable, mid_bit_enable, bit_enable, config_error;
  logic [3:0] tick_index;

  int errors = 0;
  int checks = 0;

  uart_baud_generator dut (
    .clock(clock), .reset(reset), .enable(enable), .baud_select(baud_select),
    .use_custom(use_custom), .custom_baud(custom_baud), .resync(resync),
    .sample_enable(sample_enable), .mid_bit_enable(mid_bit_enable),
    .bit_enable(bit_enable), .tick_index(tick_index), .config_error(config_error)
  );

  always #5 clock = ~clock;

  // Observe edges k_from..k_to after a restart; report the first deviation from the
  // closed-form pulse/tick_index pattern plus first-pulse edges and bit spacing.
  task automatic scan(input longint inc, input int k_from, input int k_to,
                      output int bad_k, output logic [7:0] bad_got, output logic [7:0] bad_exp,
                      output int first_s, output int first_m, output int first_b,
                      output int last_b, output int min_gap, output int max_gap);
    longint n, np;
    logic [7:0] exp_v, got_v;
    int prev_b;
    bad_k = -1; bad_got = 8'd0; bad_exp = 8'd0;
    first_s = -1; first_m = -1; first_b = -1; last_b = -1;
    min_gap = 2147483647; max_gap = 0; prev_b = -1;
    for (int k = k_from; k <= k_to; k++) begin
      @(posedge clock); #1;
      n  = (longint'(k) * inc) / CLK_HZ;
      np = (longint'(k - 1) * inc) / CLK_HZ;
      exp_v[7]   = 1'b0;
      exp_v[6]   = (n != np);
      exp_v[5]   = (n != np) && ((n % OS) == OS / 2);
      exp_v[4]   = (n != np) && ((n % OS) == 0);
      exp_v[3:0] = 4'(n % OS);
      got_v = {1'b0, sample_enable, mid_bit_enable, bit_enable, tick_index};
      if (got_v !== exp_v && bad_k < 0) begin
        bad_k = k; bad_got = got_v; bad_exp = exp_v;
      end
      if (sample_enable === 1'b1 && first_s < 0) first_s = k;
      if (mid_bit_enable === 1'b1 && first_m < 0) first_m = k;
      if (bit_enable === 1'b1) begin
        if (first_b < 0) first_b = k;
        if (prev_b >= 0) begin
          if (k - prev_b < min_gap) min_gap = k - prev_b;
          if (k - prev_b > max_gap) max_gap = k - prev_b;
        end
        prev_b = k;
        last_b = k;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; baud_select = 3'b111; use_custom = 1'b0;
    custom_baud = 20'd0; resync = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({sample_enable, mid_bit_enable, bit_enable} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {sample_enable, mid_bit_enable, bit_enable});
    end
    checks++;
    if (tick_index !== 4'd0) begin
      errors++; $display("FAIL reset_tick_index: got %0d expected 0", tick_index);
    end
    checks++;
    if (config_error !== 1'b0) begin
      errors++; $display("FAIL reset_config_error: got %b expected 0", config_error);
    end
    reset = 1'b1;
  endtask

  task automatic test_preset_115200;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    @(posedge clock); #1;
    checks++;
    if ({sample_enable, mid_bit_enable, bit_enable, tick_index, config_error} !== 8'd0) begin
      errors++; $display("FAIL b115200_restart_edge: got %b expected 0", {sample_enable, mid_bit_enable, bit_enable, tick_index, config_error});
    end
    scan(64'd1843200, 1, 21702, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin
      errors++; $display("FAIL b115200_pattern: edge %0d got %b expected %b", bk, g, e);
    end
    checks++;
    if (fs !== 28) begin errors++; $display("FAIL b115200_first_sample: got %0d expected 28", fs); end
    checks++;
    if (fm !== 218) begin errors++; $display("FAIL b115200_first_mid: got %0d expected 218", fm); end
    checks++;
    if (fb !== 435) begin errors++; $display("FAIL b115200_first_bit: got %0d expected 435", fb); end
    checks++;
    if (mn < 434 || mx > 435) begin
      errors++; $display("FAIL b115200_bit_gaps: got min %0d max %0d expected 434..435", mn, mx);
    end
    // bit 50 ends at ceil(50*50e6/115200) = 21702: no cumulative drift
    checks++;
    if (lb !== 21702) begin errors++; $display("FAIL b115200_bit50_edge: got %0d expected 21702", lb); end
  endtask

  task automatic test_enable_hold;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    resync = 1'b1;
    @(posedge clock); #1;
    resync = 1'b0;
    scan(64'd1843200, 1, 100, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin errors++; $display("FAIL hold_pre: edge %0d got %b expected %b", bk, g, e); end
    enable = 1'b0;
    // floor(100*1843200/50e6) = 3 ticks so far
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({sample_enable, mid_bit_enable, bit_enable, tick_index} !== 7'b000_0011) begin
        errors++;
        $display("FAIL hold_frozen: cycle %0d got %b expected 0000011", i, {sample_enable, mid_bit_enable, bit_enable, tick_index});
        break;
      end
    end
    enable = 1'b1;
    scan(64'd1843200, 101, 500, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin errors++; $display("FAIL hold_post: edge %0d got %b expected %b", bk, g, e); end
    checks++;
    if (fb !== 435) begin errors++; $display("FAIL hold_bit_edge: got %0d expected 435", fb); end
  endtask

  task automatic test_preset_9600;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    baud_select = 3'b011;
    @(posedge clock); #1;
    checks++;
    if ({sample_enable, tick_index, config_error} !== 6'd0) begin
      errors++; $display("FAIL b9600_restart_edge: got %b expected 0", {sample_enable, tick_index, config_error});
    end
    scan(64'd153600, 1, 5208, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin errors++; $display("FAIL b9600_pattern: edge %0d got %b expected %b", bk, g, e); end
    checks++;
    if (fs !== 326) begin errors++; $display("FAIL b9600_first_sample: got %0d expected 326", fs); end
    checks++;
    if (tick_index !== 4'd15) begin errors++; $display("FAIL b9600_last_index: got %0d expected 15", tick_index); end
    scan(64'd153600, 5209, 5209, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (fb !== 5209 || tick_index !== 4'd0) begin
      errors++; $display("FAIL b9600_bit_wrap: got edge %0d index %0d expected edge 5209 index 0", fb, tick_index);
    end
  endtask

  task automatic test_resync_on_tick;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    resync = 1'b1;
    @(posedge clock); #1;
    resync = 1'b0;
    scan(64'd153600, 1, 325, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (fs !== -1) begin errors++; $display("FAIL resync_early_tick: got %0d expected none", fs); end
    resync = 1'b1;
    @(posedge clock); #1;
    resync = 1'b0;
    checks++;
    if ({sample_enable, tick_index} !== 5'd0) begin
      errors++; $display("FAIL resync_drop: got %b expected 00000", {sample_enable, tick_index});
    end
    scan(64'd153600, 1, 326, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (fs !== 326) begin errors++; $display("FAIL resync_next_tick: got %0d expected 326", fs); end
  endtask

  task automatic test_custom;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    use_custom = 1'b1; custom_baud = 20'd1_000_000;
    @(posedge clock); #1;
    checks++;
    if (config_error !== 1'b0) begin errors++; $display("FAIL custom_1m_err: got %b expected 0", config_error); end
    scan(64'd16_000_000, 1, 40, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1 || fs !== 4) begin
      errors++; $display("FAIL custom_1m: first tick %0d expected 4, bad edge %0d got %b expected %b", fs, bk, g, e);
    end
    custom_baud = 20'd0;
    @(posedge clock); #1;
    checks++;
    if (config_error !== 1'b1) begin errors++; $display("FAIL custom_zero_err: got %b expected 1", config_error); end
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({sample_enable, mid_bit_enable, bit_enable, tick_index, config_error} !== 8'b0000_0001) begin
        errors++;
        $display("FAIL custom_zero_stall: cycle %0d got %b expected 00000001", i, {sample_enable, mid_bit_enable, bit_enable, tick_index, config_error});
        break;
      end
    end
    // largest custom rate: inc = 16777200, ticks every 2-3 edges, first at edge 3
    custom_baud = 20'hFFFFF;
    @(posedge clock); #1;
    checks++;
    if (config_error !== 1'b0) begin errors++; $display("FAIL custom_max_err: got %b expected 0", config_error); end
    scan(64'd16_777_200, 1, 60, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1 || fs !== 3) begin
      errors++; $display("FAIL custom_max: first tick %0d expected 3, bad edge %0d got %b expected %b", fs, bk, g, e);
    end
    use_custom = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({sample_enable, tick_index, config_error} !== 6'd0) begin
      errors++; $display("FAIL custom_back_to_9600: got %b expected 0", {sample_enable, tick_index, config_error});
    end
  endtask

  task automatic test_reset_then_300;
    int bk, fs, fm, fb, lb, mn, mx;
    logic [7:0] g, e;
    scan(64'd153600, 1, 1000, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin errors++; $display("FAIL midbit_run: edge %0d got %b expected %b", bk, g, e); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({sample_enable, mid_bit_enable, bit_enable, tick_index, config_error} !== 8'd0) begin
      errors++; $display("FAIL async_reset: got %b expected 0", {sample_enable, mid_bit_enable, bit_enable, tick_index, config_error});
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    scan(64'd153600, 1, 200, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1) begin errors++; $display("FAIL after_reset_9600: edge %0d got %b expected %b", bk, g, e); end
    baud_select = 3'b000;
    @(posedge clock); #1;
    checks++;
    if ({sample_enable, tick_index, config_error} !== 6'd0) begin
      errors++; $display("FAIL b300_restart_edge: got %b expected 0", {sample_enable, tick_index, config_error});
    end
    scan(64'd4800, 1, 10417, bk, g, e, fs, fm, fb, lb, mn, mx);
    checks++;
    if (bk !== -1 || fs !== 10417) begin
      errors++; $display("FAIL b300_first_tick: got %0d expected 10417, bad edge %0d", fs, bk);
    end
  endtask

  initial begin
    test_reset;
    test_preset_115200;
    test_enable_hold;
    test_preset_9600;
    test_resync_on_tick;
    test_custom;
    test_reset_then_300;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
